// File: rtl/rpn_evaluator.sv
// Reverse-Polish expression evaluator driving an external stack.
// Tokens stream in; one result (or error) is presented per expression.
module rpn_evaluator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  input  logic             tok_last,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  localparam logic [2:0] ACCEPT = 3'd0;
  localparam logic [2:0] POP_B  = 3'd1;
  localparam logic [2:0] OP     = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] SKIP   = 3'd5;
  localparam logic [2:0] FLUSH  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0]       state, state_nxt;
  logic             err, err_set;
  logic [1:0]       opcode;
  logic             last;
  logic [WIDTH-1:0] b, result;
  logic             op_load, b_load, result_load;

  // Operand a is the deeper stack entry; all results wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] alu(input logic [1:0] code,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] bb);
    logic [2*WIDTH-1:0] prod;
    prod = a * bb;
    case (code)
      2'd0:    alu = a + bb;
      2'd1:    alu = a - bb;
      2'd2:    alu = prod[WIDTH-1:0];
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    err_set     = 1'b0;
    op_load     = 1'b0;
    b_load      = 1'b0;
    result_load = 1'b0;
    tok_ready   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = tok_data;
    if (!rst) begin
      case (state)
        ACCEPT: begin
          tok_ready = 1'b1;
          if (tok_valid) begin
            if (tok_is_op) begin
              op_load   = 1'b1;
              state_nxt = POP_B;
            end else if (!stk_full) begin
              stk_push  = 1'b1;
              state_nxt = tok_last ? FINISH : ACCEPT;
            end else begin
              err_set   = 1'b1;
              state_nxt = tok_last ? FLUSH : SKIP;
            end
          end
        end
        POP_B: begin
          if (stk_empty) begin
            err_set   = 1'b1;
            state_nxt = last ? FLUSH : SKIP;
          end else begin
            b_load    = 1'b1;
            stk_pop   = 1'b1;
            state_nxt = OP;
          end
        end
        OP: begin
          if (stk_empty || opcode == 2'd3) begin
            err_set   = 1'b1;
            state_nxt = last ? FLUSH : SKIP;
          end else begin
            stk_push  = 1'b1;
            stk_pop   = 1'b1;
            stk_din   = alu(opcode, stk_dout, b);
            state_nxt = last ? FINISH : ACCEPT;
          end
        end
        FINISH: begin
          if (stk_empty) begin
            err_set   = 1'b1;
            state_nxt = FLUSH;
          end else begin
            result_load = 1'b1;
            stk_pop     = 1'b1;
            state_nxt   = CHECK;
          end
        end
        CHECK: begin
          if (!stk_empty) begin
            err_set   = 1'b1;
            state_nxt = FLUSH;
          end else begin
            state_nxt = DONE;
          end
        end
        SKIP: begin
          tok_ready = 1'b1;
          if (tok_valid && tok_last) state_nxt = FLUSH;
        end
        FLUSH: begin
          if (stk_empty) state_nxt = DONE;
          else           stk_pop   = 1'b1;
        end
        DONE: begin
          if (res_ready) state_nxt = ACCEPT;
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCEPT;
      err    <= 1'b0;
      opcode <= 2'd0;
      last   <= 1'b0;
      b      <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (err_set)                         err <= 1'b1;
      else if (state == DONE && res_ready) err <= 1'b0;
      if (op_load) begin
        opcode <= tok_data[1:0];
        last   <= tok_last;
      end
      if (b_load)      b      <= stk_dout;
      if (result_load) result <= stk_dout;
    end
  end

  assign res_valid = (state == DONE) && !rst;
  assign res_err   = res_valid && err;
  assign res_data  = (res_valid && !err) ? result : '0;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator with a behavioural 16x8 stack model and
// a scoreboard of expected {err,data} results.
module tb_rpn_evaluator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tok_valid = 1'b0, tok_ready, tok_is_op = 1'b0, tok_last = 1'b0;
  logic [7:0] tok_data = 8'd0;
  logic       stk_push, stk_pop, stk_empty, stk_full;
  logic [7:0] stk_din, stk_dout;
  logic       res_valid, res_ready = 1'b0, res_err;
  logic [7:0] res_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  logic [7:0] mem [16];
  int cnt = 0;

  rpn_evaluator #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_data(tok_data), .tok_last(tok_last),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack model: push+pop replaces the top entry.
  always_comb begin
    stk_dout  = (cnt > 0) ? mem[cnt-1] : 8'd0;
    stk_empty = (cnt == 0);
    stk_full  = (cnt == 16);
  end

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (stk_push && stk_pop && cnt > 0) mem[cnt-1] <= stk_din;
    else if (stk_push && cnt < 16) begin
      mem[cnt] <= stk_din;
      cnt <= cnt + 1;
    end else if (stk_pop && cnt > 0) cnt <= cnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic send(input logic op, input logic [7:0] d, input logic l, output int acc);
    int n = 0;
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = op; tok_data = d; tok_last = l;
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    chk("tok_ready_wait", tok_ready, 1);
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold, output int vcyc);
    int n = 0;
    logic [8:0] want;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    vcyc = cyc;
    chk({tag, "_valid"}, res_valid, 1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    chk({tag, "_data"}, res_data, want[7:0]);
    chk({tag, "_err"}, res_err, want[8]);
    chk({tag, "_stack_empty"}, cnt, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_data"}, res_data, want[7:0]);
      chk({tag, "_hold_err"}, res_err, want[8]);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    int a0, a1, a2, v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", tok_ready, 1);
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_err", res_err, 0);

    // 3 4 + back-to-back, with latency
    send(0, 8'd3, 0, a0); send(0, 8'd4, 0, a1); send(1, 8'd0, 1, a2);
    exp_q.push_back({1'b0, 8'd7});
    get_result("add", 0, v);
    chk("lat_first", v - a0, 7);
    chk("lat_op", v - a2, 5);

    // 5 9 - 2 * -> 0xF8
    send(0, 8'd5, 0, a0); send(0, 8'd9, 0, a0); send(1, 8'd1, 0, a0);
    send(0, 8'd2, 0, a0); send(1, 8'd2, 1, a0);
    exp_q.push_back({1'b0, 8'hF8});
    get_result("submul", 0, v);

    // Last operand latency: 6 -> 6
    send(0, 8'd6, 1, a0);
    exp_q.push_back({1'b0, 8'd6});
    get_result("single", 0, v);
    chk("lat_operand", v - a0, 3);

    // Multiply overflow wraps without error: 16*17 = 272 -> 16
    send(0, 8'd16, 0, a0); send(0, 8'd17, 0, a0); send(1, 8'd2, 1, a0);
    exp_q.push_back({1'b0, 8'd16});
    get_result("mulwrap", 0, v);

    // Operator on empty stack
    send(1, 8'd0, 1, a0);
    exp_q.push_back({1'b1, 8'd0});
    get_result("underflow", 0, v);

    // Leftover operand
    send(0, 8'd1, 0, a0); send(0, 8'd2, 1, a0);
    exp_q.push_back({1'b1, 8'd0});
    get_result("leftover", 0, v);

    // Illegal opcode
    send(0, 8'd1, 0, a0); send(0, 8'd2, 0, a0); send(1, 8'd3, 1, a0);
    exp_q.push_back({1'b1, 8'd0});
    get_result("illegal", 0, v);

    // 17 operands overflow the 16-deep stack, rest skipped
    for (int i = 1; i <= 16; i++) send(0, 8'(i), 0, a0);
    chk("stack_full_count", cnt, 16);
    send(0, 8'd17, 0, a0);
    send(0, 8'd99, 0, a0); send(1, 8'd0, 1, a0);
    exp_q.push_back({1'b1, 8'd0});
    get_result("overflow", 0, v);

    // Result held stable while res_ready stays low
    send(0, 8'd20, 0, a0); send(0, 8'd22, 0, a0); send(1, 8'd0, 1, a0);
    exp_q.push_back({1'b0, 8'd42});
    get_result("hold", 4, v);

    // Reset while in OP abandons the expression
    send(0, 8'd3, 0, a0); send(0, 8'd4, 0, a0); send(1, 8'd0, 1, a0);
    @(negedge clk);
    @(negedge clk);
    chk("in_op_pushpop", {stk_push, stk_pop}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", tok_ready, 0);
    chk("mid_rst_push", stk_push, 0);
    chk("mid_rst_pop", stk_pop, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("after_rst_ready", tok_ready, 1);
    chk("after_rst_valid", res_valid, 0);
    chk("after_rst_err", res_err, 0);
    chk("after_rst_data", res_data, 0);
    chk("after_rst_pushpop", {stk_push, stk_pop}, 2'b00);
    chk("after_rst_stack", cnt, 0);

    // Normal operation resumes
    send(0, 8'd200, 0, a0); send(0, 8'd100, 0, a0); send(1, 8'd0, 1, a0);
    exp_q.push_back({1'b0, 8'd44});
    get_result("resume", 0, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpn_evaluator.md
RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 Parameter WIDTH, default 8: operand, result and stack data width.
REQ-002 Parameter DEPTH, default 16: capacity of the attached stack; informational only, because overflow is detected through stk_full.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port tok_valid, input, 1 bit: a token is present on the token inputs.
REQ-006 Port tok_ready, output, 1 bit: the block accepts the token this cycle.
REQ-007 Port tok_is_op, input, 1 bit: 1 = operator token, 0 = operand token.
REQ-008 Port tok_data, input, WIDTH bits: operand value, or opcode in bits [1:0] (0 add, 1 sub, 2 mul, 3 illegal).
REQ-009 Port tok_last, input, 1 bit: final token of the expression.
REQ-010 Port stk_push, output, 1 bit: push request to the stack.
REQ-011 Port stk_pop, output, 1 bit: pop request to the stack.
REQ-012 Port stk_din, output, WIDTH bits: data to push, or replacement value when push and pop are both asserted.
REQ-013 Port stk_dout, input, WIDTH bits: combinational top-of-stack.
REQ-014 Port stk_empty, input, 1 bit: the stack is empty.
REQ-015 Port stk_full, input, 1 bit: the stack is full.
REQ-016 Port res_valid, output, 1 bit: a result is presented.
REQ-017 Port res_ready, input, 1 bit: the consumer takes the result.
REQ-018 Port res_data, output, WIDTH bits: the expression result.
REQ-019 Port res_err, output, 1 bit: the expression was malformed or overflowed.

Function
REQ-020 FSM states SHALL be ACCEPT, POP_B, OP, FINISH, CHECK, SKIP, FLUSH, DONE.
REQ-021 A token transfers only when tok_valid and tok_ready are both 1; tok_ready SHALL be 1 only in ACCEPT and SKIP.
REQ-022 ACCEPT, operand token, stk_full=0: drive stk_push=1 and stk_din=tok_data in the same cycle; next state is FINISH if tok_last, else ACCEPT.
REQ-023 ACCEPT, operand token, stk_full=1: do not push; set the error flag; next state is FLUSH if tok_last, else SKIP.
REQ-024 ACCEPT, operator token: latch the opcode and tok_last; next state is POP_B, with no stack action that cycle.
REQ-025 POP_B: if stk_empty, set error and go to SKIP/FLUSH per the latched last; else latch b=stk_dout, drive stk_pop=1, go to OP.
REQ-026 OP: if stk_empty or opcode=3, set error and go to SKIP/FLUSH.
REQ-026a OP, otherwise: a=stk_dout; drive stk_push=1, stk_pop=1 and stk_din=a op b (top replaced); next state is FINISH if the latched last is set, else ACCEPT.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH: add gives a+b, sub gives a-b (a = deeper operand), mul gives the low WIDTH bits of a*b; arithmetic overflow is not an error.
REQ-028 FINISH: if stk_empty, set error and go to FLUSH; else latch the result register=stk_dout, drive stk_pop=1, go to CHECK.
REQ-029 CHECK: if stk_empty=0 (leftover operands), set error and go to FLUSH; else go to DONE.
REQ-030 SKIP: hold tok_ready=1 and discard tokens; on accepting tok_last, go to FLUSH.
REQ-031 FLUSH: drive stk_pop=1 while stk_empty=0; when stk_empty=1, go to DONE with stk_pop=0 that cycle.
REQ-032 DONE: res_valid=1, res_err=error flag, res_data=result register (forced 0 when error); hold all three stable until res_ready.
REQ-033 DONE with res_ready=1: clear the error flag and go to ACCEPT next cycle.
REQ-034 Latency for a well-formed expression: the last operand gives res_valid 3 cycles after acceptance; the last operator gives res_valid 5 cycles after acceptance.
REQ-035 stk_push and stk_pop SHALL be 0 in every state and condition not listed above; push and pop are never both asserted on an empty stack.

Reset
REQ-036 When rst=1 at a clock edge, next state is ACCEPT, the error flag, b and the result register clear to 0, and res_valid=0 and res_err=0.
REQ-037 Reset mid-expression SHALL abandon the expression; stack contents are the stack's responsibility (it resets with the same rst).
REQ-038 During the reset cycle tok_ready=0, stk_push=0 and stk_pop=0.

Verification
REQ-039 Tokens 3, 4, +(last), back-to-back, with a DEPTH 16 WIDTH 8 stack model -> res_valid on cycle 7 after the first accept; res_data=7, res_err=0, stack empty afterwards.
REQ-040 Tokens 5, 9, -, 2, *(last) -> res_data=0xF8 ((5-9)*2 mod 256 = 248), res_err=0.
REQ-041 Token +(last) on an empty stack -> POP_B error, FLUSH, then res_valid with res_err=1 and res_data=0.
REQ-042 Tokens 1, 2(last) -> CHECK finds a leftover operand, FLUSH pops it, res_err=1, stack empty.
REQ-043 Push 17 operands into the DEPTH 16 stack, then further tokens through last -> error on the 17th operand, SKIP consumes tokens through last, FLUSH pops 16, res_err=1.
REQ-044 Assert rst for one cycle while in OP, and hold res_ready=0 in DONE for 4 cycles in a separate run -> after reset the state is ACCEPT with all outputs 0; held results stay stable for all 4 cycles.
